prog_mem_arbiter: RTL



---
 rtl/prog_mem_arbiter_pkg.sv | 19 +
 rtl/prog_mem_arbiter.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/prog_mem_arbiter_pkg.sv
// rtl/prog_mem_arbiter_pkg.sv - shared state, owner codes and default widths for the program RAM arbiter
package prog_mem_arbiter_pkg;

    localparam int DEF_AW = 8;
    localparam int DEF_DW = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CPU_RD  = 3'd1,
        ST_CPU_RSP = 3'd2,
        ST_LD_ACC  = 3'd3,
        ST_LD_RSP  = 3'd4
    } arb_state_e;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LD   = 2'b10;

endpackage

// File: rtl/prog_mem_arbiter.sv
// rtl/prog_mem_arbiter.sv - round-robin sharing of the program RAM between CPU fetch and the loader
module prog_mem_arbiter
    import prog_mem_arbiter_pkg::*;
#(
    parameter int AW = DEF_AW,
    parameter int DW = DEF_DW
) (
    input  logic          clk,
    input  logic          CLB,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    input  logic          ld_lock,
    output logic [DW-1:0] ld_rdata,
    output logic          ld_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner
);

    arb_state_e    state_q, state_d;
    logic          last_ld_q, last_ld_d;     // 1 = loader was granted most recently
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] ld_rdata_q, ld_rdata_d;
    logic          cpu_ack_q, cpu_ack_d;
    logic          ld_ack_q, ld_ack_d;

    logic cpu_elig;
    logic ld_elig;
    logic grant_cpu;
    logic grant_ld;

    // A requester whose ack is showing this cycle is ignored so a held request does not repeat.
    always_comb begin
        cpu_elig  = cpu_req && !ld_lock && !cpu_ack_q;
        ld_elig   = ld_req && !ld_ack_q;
        grant_cpu = cpu_elig && (!ld_elig || last_ld_q);
        grant_ld  = ld_elig && !grant_cpu;
    end

    // Next-state logic: arbitrate in IDLE, then walk the fixed access/response sequence.
    always_comb begin
        state_d     = state_q;
        last_ld_d   = last_ld_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        cpu_ack_d   = 1'b0;
        ld_ack_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_cpu) begin
                    state_d   = ST_CPU_RD;
                    last_ld_d = 1'b0;
                    addr_d    = cpu_addr;
                    we_d      = 1'b0;
                end else if (grant_ld) begin
                    state_d   = ST_LD_ACC;
                    last_ld_d = 1'b1;
                    addr_d    = ld_addr;
                    we_d      = ld_we;
                    wdata_d   = ld_wdata;
                end
            end
            ST_CPU_RD: begin
                state_d = ST_CPU_RSP;
            end
            ST_CPU_RSP: begin
                state_d     = ST_IDLE;
                cpu_ack_d   = 1'b1;
                cpu_rdata_d = mem_rdata;
            end
            ST_LD_ACC: begin
                state_d = ST_LD_RSP;
            end
            ST_LD_RSP: begin
                state_d  = ST_IDLE;
                ld_ack_d = 1'b1;
                if (!we_q) begin
                    ld_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, arbitration history, latched transaction and response registers.
    always_ff @(posedge clk or negedge CLB) begin
        if (!CLB) begin
            state_q     <= ST_IDLE;
            last_ld_q   <= 1'b1;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_ld_q   <= last_ld_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
        end
    end

    // RAM strobes and owner are a pure decode of the state so reset drops them at once.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        owner     = OWN_NONE;
        case (state_q)
            ST_CPU_RD: begin
                mem_en   = 1'b1;
                mem_addr = addr_q;
                owner    = OWN_CPU;
            end
            ST_CPU_RSP: begin
                owner = OWN_CPU;
            end
            ST_LD_ACC: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                owner     = OWN_LD;
            end
            ST_LD_RSP: begin
                owner = OWN_LD;
            end
            default: begin
                owner = OWN_NONE;
            end
        endcase
    end

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_rdata  = ld_rdata_q;
    assign ld_ack    = ld_ack_q;

endmodule
